// File: rtl/dram_port_arbiter.sv
// Arbitrates the single SDRAM controller port between the 68k/cache path and
// the video fetch engine, with starvation ageing and CAS-latency burst tracking.
module dram_port_arbiter #(
  parameter int unsigned MAX_WAIT    = 64,
  parameter int unsigned CAS_LATENCY = 2,
  parameter int unsigned BURST_LEN   = 8
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        Cpu_Select_L,
  input  logic        Cpu_AS_L,
  input  logic        Cpu_WE_L,
  input  logic        Cpu_UDS_L,
  input  logic        Cpu_LDS_L,
  input  logic [31:0] Cpu_Address,
  input  logic [15:0] Cpu_DataOut,
  output logic        Cpu_Dtack_L,
  input  logic        Vid_Req_H,
  input  logic        Vid_Urgent_H,
  input  logic [31:0] Vid_Address,
  output logic        Vid_Ack_H,
  output logic        Vid_DataValid_H,
  output logic [2:0]  Vid_WordIndex,
  output logic        Vid_Done_H,
  output logic        Dram_Select_L,
  output logic        Dram_AS_L,
  output logic        Dram_WE_L,
  output logic        Dram_UDS_L,
  output logic        Dram_LDS_L,
  output logic [31:0] Dram_Address,
  output logic [15:0] Dram_DataOut,
  input  logic [15:0] Dram_DataIn,
  input  logic        Dram_Dtack_L,
  input  logic        Dram_CAS_L,
  input  logic        Dram_RAS_L,
  output logic [1:0]  Grant,
  output logic [2:0]  ArbState
);

  localparam int unsigned WAIT_W    = 16;
  localparam int unsigned LAT_W     = 4;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAT_EXTRA = (CAS_LATENCY > 1) ? CAS_LATENCY - 2 : 0;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_CPU_OWN     = 3'd1;
  localparam logic [2:0] ST_VID_START   = 3'd2;
  localparam logic [2:0] ST_VID_LATENCY = 3'd3;
  localparam logic [2:0] ST_VID_BURST   = 3'd4;
  localparam logic [2:0] ST_VID_END     = 3'd5;
  localparam logic [2:0] ST_GAP         = 3'd6;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_VID  = 2'b10;

  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LAT_EXTRA);
  localparam logic [IDX_W-1:0]  WORD_LAST = IDX_W'(BURST_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic              ack_q, ack_d;

  logic cpu_req;
  logic vid_cas;
  logic vid_aged;
  logic vid_entry;

  // Dram_DataIn is wired straight to both requesters outside this block.
  logic unused_inputs;
  assign unused_inputs = ^{Dram_DataIn, Vid_Address[3:0]};

  assign cpu_req   = !Cpu_Select_L && !Cpu_AS_L;
  assign vid_cas   = !Dram_CAS_L && Dram_RAS_L;
  assign vid_aged  = (wait_cnt_q >= WAIT_MAX);
  assign vid_entry = (state_d == ST_VID_START) && (state_q != ST_VID_START);

  // Next-state and sequencing counters
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Vid_Req_H && (Vid_Urgent_H || vid_aged)) state_d = ST_VID_START;
        else if (cpu_req)                            state_d = ST_CPU_OWN;
        else if (Vid_Req_H)                          state_d = ST_VID_START;
      end
      ST_CPU_OWN: begin
        if (Cpu_AS_L || Cpu_Select_L) state_d = ST_GAP;
      end
      ST_VID_START: begin
        lat_cnt_d = '0;
        if (vid_cas) state_d = ST_VID_LATENCY;
      end
      ST_VID_LATENCY: begin
        if (lat_cnt_q >= LAT_LAST) begin
          state_d    = ST_VID_BURST;
          word_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_VID_BURST: begin
        if (word_cnt_q == WORD_LAST) begin
          state_d    = ST_VID_END;
          word_cnt_d = '0;
        end else begin
          word_cnt_d = word_cnt_q + IDX_W'(1);
        end
      end
      ST_VID_END: state_d = ST_GAP;
      ST_GAP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Starvation age, grant and ack follow the next state
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    grant_d    = GNT_NONE;
    ack_d      = vid_entry;
    if (vid_entry)
      wait_cnt_d = '0;
    else if (Vid_Req_H && (grant_q != GNT_VID) && (wait_cnt_q < WAIT_MAX))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    case (state_d)
      ST_CPU_OWN:                                           grant_d = GNT_CPU;
      ST_VID_START, ST_VID_LATENCY, ST_VID_BURST, ST_VID_END: grant_d = GNT_VID;
      default:                                              grant_d = GNT_NONE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      word_cnt_q <= '0;
      grant_q    <= GNT_NONE;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      word_cnt_q <= word_cnt_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
    end
  end

  // DRAM port mux: CPU passes through with zero latency, video drives a fixed read
  always_comb begin
    Dram_Select_L = 1'b1;
    Dram_AS_L     = 1'b1;
    Dram_WE_L     = 1'b1;
    Dram_UDS_L    = 1'b1;
    Dram_LDS_L    = 1'b1;
    Dram_Address  = '0;
    Dram_DataOut  = '0;
    Cpu_Dtack_L   = 1'b1;
    case (state_q)
      ST_CPU_OWN: begin
        Dram_Select_L = Cpu_Select_L;
        Dram_AS_L     = Cpu_AS_L;
        Dram_WE_L     = Cpu_WE_L;
        Dram_UDS_L    = Cpu_UDS_L;
        Dram_LDS_L    = Cpu_LDS_L;
        Dram_Address  = Cpu_Address;
        Dram_DataOut  = Cpu_DataOut;
        Cpu_Dtack_L   = Dram_Dtack_L;
      end
      ST_VID_START, ST_VID_LATENCY, ST_VID_BURST: begin
        Dram_Select_L = 1'b0;
        Dram_AS_L     = 1'b0;
        Dram_UDS_L    = 1'b0;
        Dram_LDS_L    = 1'b0;
        Dram_Address  = {Vid_Address[31:4], 4'b0000};
      end
      default: ;
    endcase
  end

  assign Vid_Ack_H       = ack_q;
  assign Vid_DataValid_H = (state_q == ST_VID_BURST);
  assign Vid_WordIndex   = word_cnt_q;
  assign Vid_Done_H      = (state_q == ST_VID_END);
  assign Grant           = grant_q;
  assign ArbState        = state_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: reset, CPU pass-through, video burst
// timing, refresh filtering, arbitration priority and starvation ageing.
module tb_dram_port_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0, S_CPU = 3'd1, S_VSTART = 3'd2, S_VLAT = 3'd3;
  localparam logic [2:0] S_VBURST = 3'd4, S_VEND = 3'd5, S_GAP = 3'd6;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b1;
  logic        Cpu_Select_L, Cpu_AS_L, Cpu_WE_L, Cpu_UDS_L, Cpu_LDS_L;
  logic [31:0] Cpu_Address;
  logic [15:0] Cpu_DataOut;
  logic        Cpu_Dtack_L;
  logic        Vid_Req_H, Vid_Urgent_H;
  logic [31:0] Vid_Address;
  logic        Vid_Ack_H, Vid_DataValid_H, Vid_Done_H;
  logic [2:0]  Vid_WordIndex;
  logic        Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L;
  logic [31:0] Dram_Address;
  logic [15:0] Dram_DataOut, Dram_DataIn;
  logic        Dram_Dtack_L, Dram_CAS_L, Dram_RAS_L;
  logic [1:0]  Grant;
  logic [2:0]  ArbState;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  dram_port_arbiter #(.MAX_WAIT(64), .CAS_LATENCY(2), .BURST_LEN(8)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .Cpu_Select_L(Cpu_Select_L), .Cpu_AS_L(Cpu_AS_L), .Cpu_WE_L(Cpu_WE_L),
    .Cpu_UDS_L(Cpu_UDS_L), .Cpu_LDS_L(Cpu_LDS_L), .Cpu_Address(Cpu_Address),
    .Cpu_DataOut(Cpu_DataOut), .Cpu_Dtack_L(Cpu_Dtack_L),
    .Vid_Req_H(Vid_Req_H), .Vid_Urgent_H(Vid_Urgent_H), .Vid_Address(Vid_Address),
    .Vid_Ack_H(Vid_Ack_H), .Vid_DataValid_H(Vid_DataValid_H),
    .Vid_WordIndex(Vid_WordIndex), .Vid_Done_H(Vid_Done_H),
    .Dram_Select_L(Dram_Select_L), .Dram_AS_L(Dram_AS_L), .Dram_WE_L(Dram_WE_L),
    .Dram_UDS_L(Dram_UDS_L), .Dram_LDS_L(Dram_LDS_L), .Dram_Address(Dram_Address),
    .Dram_DataOut(Dram_DataOut), .Dram_DataIn(Dram_DataIn),
    .Dram_Dtack_L(Dram_Dtack_L), .Dram_CAS_L(Dram_CAS_L), .Dram_RAS_L(Dram_RAS_L),
    .Grant(Grant), .ArbState(ArbState)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_idle();
    Cpu_Select_L = 1'b1; Cpu_AS_L = 1'b1; Cpu_WE_L = 1'b1; Cpu_UDS_L = 1'b1; Cpu_LDS_L = 1'b1;
    Cpu_Address = '0; Cpu_DataOut = '0;
    Vid_Req_H = 1'b0; Vid_Urgent_H = 1'b0; Vid_Address = '0;
    Dram_DataIn = 16'h5A5A; Dram_Dtack_L = 1'b1; Dram_CAS_L = 1'b1; Dram_RAS_L = 1'b1;
  endtask

  // Presents one CAS from VidStart and runs the burst through to Gap.
  task automatic finish_burst();
    int n;
    n = 0;
    Dram_CAS_L = 1'b0; Dram_RAS_L = 1'b1;
    step();
    Dram_CAS_L = 1'b1;
    while (ArbState !== S_GAP && n < 20) begin
      if (Vid_Done_H === 1'b1) Vid_Req_H = 1'b0;
      step();
      n++;
    end
    checks++; if (ArbState !== S_GAP) begin errors++; $display("FAIL burst_timeout state=%0d want=%0d", ArbState, S_GAP); end
  endtask

  task automatic test_reset();
    drive_idle();
    #1 Reset_L = 1'b0;
    #1;
    checks++; if (ArbState !== S_IDLE) begin errors++; $display("FAIL rst_state got=%0d want=%0d", ArbState, S_IDLE); end
    checks++; if (Grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b want=00", Grant); end
    checks++; if ({Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L, Cpu_Dtack_L} !== 6'b111111) begin
      errors++; $display("FAIL rst_ctl_l got=%b want=111111", {Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L, Cpu_Dtack_L}); end
    checks++; if ({Dram_Address, Dram_DataOut} !== 48'h0) begin errors++; $display("FAIL rst_addr_data got=%h want=0", {Dram_Address, Dram_DataOut}); end
    checks++; if ({Vid_Ack_H, Vid_DataValid_H, Vid_Done_H, Vid_WordIndex} !== 6'b0) begin
      errors++; $display("FAIL rst_vid got=%b want=000000", {Vid_Ack_H, Vid_DataValid_H, Vid_Done_H, Vid_WordIndex}); end
    step(); step();
    Reset_L = 1'b1;
    step();
  endtask

  task automatic test_cpu_passthrough();
    Cpu_Address = 32'h0800_0010; Cpu_DataOut = 16'h1234; Cpu_WE_L = 1'b1;
    Cpu_UDS_L = 1'b0; Cpu_LDS_L = 1'b0; Cpu_Select_L = 1'b0; Cpu_AS_L = 1'b0;
    #1;
    checks++; if (Dram_AS_L !== 1'b1) begin errors++; $display("FAIL cpu_pre_grant_as got=%b want=1", Dram_AS_L); end
    step();
    checks++; if (ArbState !== S_CPU) begin errors++; $display("FAIL cpu_state got=%0d want=%0d", ArbState, S_CPU); end
    checks++; if (Grant !== 2'b01) begin errors++; $display("FAIL cpu_grant got=%b want=01", Grant); end
    checks++; if (Dram_Address !== 32'h0800_0010) begin errors++; $display("FAIL cpu_addr got=%h want=08000010", Dram_Address); end
    checks++; if ({Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L} !== 5'b00100) begin
      errors++; $display("FAIL cpu_ctl got=%b want=00100", {Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L}); end
    checks++; if (Cpu_Dtack_L !== 1'b1) begin errors++; $display("FAIL cpu_dtack_hi got=%b want=1", Cpu_Dtack_L); end
    Dram_Dtack_L = 1'b0; Cpu_WE_L = 1'b0; Cpu_DataOut = 16'hBEEF;
    #1;
    checks++; if (Cpu_Dtack_L !== 1'b0) begin errors++; $display("FAIL cpu_dtack_lo got=%b want=0", Cpu_Dtack_L); end
    checks++; if ({Dram_WE_L, Dram_DataOut} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL cpu_write got=%b/%h want=0/beef", Dram_WE_L, Dram_DataOut); end
    step();
    checks++; if (ArbState !== S_CPU) begin errors++; $display("FAIL cpu_hold got=%0d want=%0d", ArbState, S_CPU); end
    Cpu_AS_L = 1'b1; Dram_Dtack_L = 1'b1;
    #1;
    checks++; if (Dram_AS_L !== 1'b1) begin errors++; $display("FAIL cpu_as_follow got=%b want=1", Dram_AS_L); end
    step();
    checks++; if (ArbState !== S_GAP) begin errors++; $display("FAIL cpu_gap got=%0d want=%0d", ArbState, S_GAP); end
    checks++; if ({Dram_Select_L, Dram_AS_L, Grant} !== 4'b1100) begin errors++; $display("FAIL cpu_gap_ctl got=%b want=1100", {Dram_Select_L, Dram_AS_L, Grant}); end
    drive_idle();
    step();
    checks++; if (ArbState !== S_IDLE) begin errors++; $display("FAIL cpu_back_idle got=%0d want=%0d", ArbState, S_IDLE); end
  endtask

  task automatic test_video_burst();
    Vid_Address = 32'h0810_0024; Vid_Req_H = 1'b1;
    step();
    checks++; if ({ArbState, Vid_Ack_H, Grant} !== {S_VSTART, 1'b1, 2'b10}) begin
      errors++; $display("FAIL vid_start got=%0d/%b/%b want=2/1/10", ArbState, Vid_Ack_H, Grant); end
    checks++; if (Dram_Address !== 32'h0810_0020) begin errors++; $display("FAIL vid_addr got=%h want=08100020", Dram_Address); end
    checks++; if ({Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L, Dram_DataOut} !== {5'b00100, 16'h0}) begin
      errors++; $display("FAIL vid_ctl got=%b/%h want=00100/0000", {Dram_Select_L, Dram_AS_L, Dram_WE_L, Dram_UDS_L, Dram_LDS_L}, Dram_DataOut); end
    step();
    checks++; if ({ArbState, Vid_Ack_H} !== {S_VSTART, 1'b0}) begin errors++; $display("FAIL vid_ack_once got=%0d/%b want=2/0", ArbState, Vid_Ack_H); end
    Dram_CAS_L = 1'b0;
    step();
    Dram_CAS_L = 1'b1;
    checks++; if ({ArbState, Vid_DataValid_H} !== {S_VLAT, 1'b0}) begin errors++; $display("FAIL vid_latency got=%0d/%b want=3/0", ArbState, Vid_DataValid_H); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) Vid_Req_H = 1'b0;
      checks++; if ({Vid_DataValid_H, Vid_WordIndex, Vid_Done_H} !== {1'b1, 3'(i), 1'b0}) begin
        errors++; $display("FAIL vid_word%0d got=%b/%0d/%b want=1/%0d/0", i, Vid_DataValid_H, Vid_WordIndex, Vid_Done_H, i); end
    end
    step();
    checks++; if ({Vid_Done_H, Vid_DataValid_H, Dram_AS_L, Dram_Select_L} !== 4'b1011) begin
      errors++; $display("FAIL vid_done got=%b want=1011", {Vid_Done_H, Vid_DataValid_H, Dram_AS_L, Dram_Select_L}); end
    step();
    checks++; if ({ArbState, Vid_Done_H, Grant} !== {S_GAP, 1'b0, 2'b00}) begin
      errors++; $display("FAIL vid_gap got=%0d/%b/%b want=6/0/00", ArbState, Vid_Done_H, Grant); end
    step();
    checks++; if (ArbState !== S_IDLE) begin errors++; $display("FAIL vid_back_idle got=%0d want=%0d", ArbState, S_IDLE); end
  endtask

  task automatic test_refresh_ignored();
    Vid_Address = 32'h0000_1230; Vid_Req_H = 1'b1;
    step();
    Dram_CAS_L = 1'b0; Dram_RAS_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({ArbState, Vid_DataValid_H} !== {S_VSTART, 1'b0}) begin
        errors++; $display("FAIL refresh_hold%0d got=%0d/%b want=2/0", i, ArbState, Vid_DataValid_H); end
    end
    Dram_RAS_L = 1'b1;
    finish_burst();
    step();
  endtask

  task automatic test_simultaneous();
    Cpu_Address = 32'h0000_0400; Cpu_Select_L = 1'b0; Cpu_AS_L = 1'b0; Vid_Req_H = 1'b1;
    step();
    checks++; if ({ArbState, Grant} !== {S_CPU, 2'b01}) begin errors++; $display("FAIL simul_cpu_first got=%0d/%b want=1/01", ArbState, Grant); end
    Cpu_AS_L = 1'b1;
    step();
    checks++; if (ArbState !== S_GAP) begin errors++; $display("FAIL simul_gap got=%0d want=%0d", ArbState, S_GAP); end
    step();
    step();
    checks++; if ({ArbState, Vid_Ack_H} !== {S_VSTART, 1'b1}) begin errors++; $display("FAIL simul_vid_second got=%0d/%b want=2/1", ArbState, Vid_Ack_H); end
    finish_burst();
    step();
    Cpu_AS_L = 1'b0; Vid_Req_H = 1'b1; Vid_Urgent_H = 1'b1;
    step();
    checks++; if ({ArbState, Grant, Cpu_Dtack_L} !== {S_VSTART, 2'b10, 1'b1}) begin
      errors++; $display("FAIL urgent_vid_first got=%0d/%b/%b want=2/10/1", ArbState, Grant, Cpu_Dtack_L); end
    Vid_Urgent_H = 1'b0;
    finish_burst();
    step();
    step();
    checks++; if (ArbState !== S_CPU) begin errors++; $display("FAIL urgent_cpu_after got=%0d want=%0d", ArbState, S_CPU); end
    drive_idle();
    step(); step();
  endtask

  task automatic test_starvation();
    int wmodel, own, denied;
    bit granted, was_idle, exp_vid;
    wmodel = 0; own = 0; denied = 0; granted = 1'b0;
    Cpu_Select_L = 1'b0; Cpu_AS_L = 1'b0; Vid_Req_H = 1'b1; Vid_Urgent_H = 1'b0;
    for (int c = 0; c < 200 && !granted; c++) begin
      if (ArbState === S_CPU) begin own++; Cpu_AS_L = (own == 3); end
      else begin own = 0; Cpu_AS_L = 1'b0; end
      was_idle = (ArbState === S_IDLE);
      exp_vid = (wmodel >= 64);
      step();
      if (wmodel < 64) wmodel++;
      if (was_idle) begin
        checks++; if (ArbState !== (exp_vid ? S_VSTART : S_CPU)) begin
          errors++; $display("FAIL starve_decision cyc=%0d got=%0d want=%0d", c, ArbState, exp_vid ? S_VSTART : S_CPU); end
        if (exp_vid) granted = 1'b1; else denied++;
      end
    end
    checks++; if (!granted) begin errors++; $display("FAIL starve_timeout granted=0 want=1"); end
    checks++; if (denied != 13) begin errors++; $display("FAIL starve_denied got=%0d want=13", denied); end
    Cpu_AS_L = 1'b0;
    finish_burst();
    step(); step();
    checks++; if (ArbState !== S_CPU) begin errors++; $display("FAIL starve_cpu_resume got=%0d want=%0d", ArbState, S_CPU); end
    drive_idle();
    step(); step();
  endtask

  task automatic test_reset_mid_burst();
    bit done_seen;
    Vid_Address = 32'h0020_0000; Vid_Req_H = 1'b1;
    step();
    Dram_CAS_L = 1'b0;
    step();
    Dram_CAS_L = 1'b1;
    step(); step(); step(); step();
    checks++; if ({Vid_DataValid_H, Vid_WordIndex} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL rstb_word3 got=%b/%0d want=1/3", Vid_DataValid_H, Vid_WordIndex); end
    #2 Reset_L = 1'b0; Vid_Req_H = 1'b0;
    #1;
    checks++; if ({ArbState, Grant, Dram_AS_L, Vid_DataValid_H, Vid_Done_H} !== {S_IDLE, 2'b00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstb_async got=%0d/%b/%b/%b/%b want=0/00/1/0/0", ArbState, Grant, Dram_AS_L, Vid_DataValid_H, Vid_Done_H); end
    step();
    checks++; if ({Grant, Dram_AS_L, Vid_DataValid_H, Vid_Done_H, Vid_WordIndex} !== {2'b00, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL rstb_next got=%b/%b/%b/%b/%0d want=00/1/0/0/0", Grant, Dram_AS_L, Vid_DataValid_H, Vid_Done_H, Vid_WordIndex); end
    Reset_L = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Vid_Done_H !== 1'b0 || ArbState !== S_IDLE) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL rstb_no_done got=1 want=0"); end
  endtask

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_video_burst();
    test_refresh_ignored();
    test_simultaneous();
    test_starvation();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
